// File: rtl/alu_arbiter_2.sv
// Round-robin arbiter sharing one external alu_32 between two requesters, one op in flight.
// Optional macro ALU_ARB_ILLEGAL_CHECK_EN answers illegal control codes with an error response.
module alu_arbiter_2 #(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  // Request channels: an op transfers on a cycle where req_valid_i && req_ready_i.
  // Response channels: a response transfers on a cycle where rsp_valid_i && rsp_ready_i.
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [3:0]  req_control_0,
  input  logic [4:0]  req_shamt_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  input  logic [3:0]  req_control_1,
  input  logic [4:0]  req_shamt_1,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_carry_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        prio;
  logic        gnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_control;
  logic [4:0]  op_shamt;

  logic        pick;
  logic        req_fire;
  logic        rsp_take;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_control;
  logic [4:0]  sel_shamt;

  // Priority only matters on a tie; a lone requester always wins.
  always_comb begin
    pick        = (req_valid_0 && req_valid_1) ? prio : req_valid_1;
    req_ready_0 = (state == IDLE) && req_valid_0 && !pick;
    req_ready_1 = (state == IDLE) && req_valid_1 && pick;
    req_fire    = req_ready_0 || req_ready_1;
    sel_a       = pick ? req_a_1       : req_a_0;
    sel_b       = pick ? req_b_1       : req_b_0;
    sel_control = pick ? req_control_1 : req_control_0;
    sel_shamt   = pick ? req_shamt_1   : req_shamt_0;
    rsp_take    = gnt ? rsp_ready_1 : rsp_ready_0;
  end

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  logic illegal;

  always_comb begin
    illegal = 1'b1;
    if (sel_control == 4'b0000 || sel_control == 4'b0010 ||
        (sel_control >= 4'b1000 && sel_control <= 4'b1110)) begin
      illegal = 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= INIT_PRIO;
      gnt          <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_control   <= '0;
      op_shamt     <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            gnt        <= pick;
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_control <= sel_control;
            op_shamt   <= sel_shamt;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
            // Illegal ops never reach the ALU; answer with a zeroed error response.
            if (illegal) begin
              rsp_result   <= '0;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_zero     <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_valid_0  <= !pick;
              rsp_valid_1  <= pick;
              state        <= RESP;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_carry    <= alu_carry_out;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
          rsp_err      <= 1'b0;
`endif
          rsp_valid_0  <= !gnt;
          rsp_valid_1  <= gnt;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            prio        <= !gnt;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_control = op_control;
  assign alu_shamt   = op_shamt;
  assign dbg_state   = state;

endmodule

// File: tb/tb_alu_arbiter_2.sv
// Bench for alu_arbiter_2: behavioural ALU, transaction-level arbiter model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
`timescale 1ns/1ps
module tb_alu_arbiter_2;
  localparam bit INIT_PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid[2];
  logic [31:0] req_a[2];
  logic [31:0] req_b[2];
  logic [3:0]  req_ctl[2];
  logic [4:0]  req_shamt[2];
  logic        rsp_ready[2];
  logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_overflow, rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        alu_carry_out, alu_overflow, alu_zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_2 #(.INIT_PRIO(INIT_PRIO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid[0]), .req_ready_0(req_ready_0),
    .req_a_0(req_a[0]), .req_b_0(req_b[0]), .req_control_0(req_ctl[0]), .req_shamt_0(req_shamt[0]),
    .req_valid_1(req_valid[1]), .req_ready_1(req_ready_1),
    .req_a_1(req_a[1]), .req_b_1(req_b[1]), .req_control_1(req_ctl[1]), .req_shamt_1(req_shamt[1]),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready[0]),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready[1]),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .dbg_state(dbg_state)
  );

  // Stand-in for the external alu_32: {result, carry, overflow, zero}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] ctl, input logic [4:0] sh);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (ctl)
      4'b0000: r = b << sh;
      4'b0010: r = b >> sh;
      4'b1000, 4'b1001: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        if (ctl == 4'b1000) v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b1010, 4'b1011: begin
        r = a - b;
        c = (a < b);
        if (ctl == 4'b1010) v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b1100: r = a & b;
      4'b1101: r = a | b;
      4'b1110: r = a ^ b;
      default: r = ~(a | b);
    endcase
    return {r, c, v, (r == 32'd0)};
  endfunction

  always_comb {alu_result, alu_carry_out, alu_overflow, alu_zero} = alu_fn(alu_a, alu_b, alu_control, alu_shamt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Transaction-level model: idle/busy, who holds the op, when its response is due.
  bit          m_busy = 1'b0;
  bit          m_prio = INIT_PRIO;
  bit          m_clean = 1'b1;
  logic        m_g = 1'b0;
  int          m_due = 0;
  logic [34:0] m_exp = '0;
  logic        m_err = 1'b0;
  logic        mg, e_r0, e_r1, e_v0, e_v1, m_illegal;

  always @(negedge clk) begin
    if (chk_en) begin
      mg   = (req_valid[0] && req_valid[1]) ? m_prio : req_valid[1];
      e_r0 = !m_busy && req_valid[0] && !mg;
      e_r1 = !m_busy && req_valid[1] && mg;
      e_v0 = m_busy && (cyc >= m_due) && !m_g;
      e_v1 = m_busy && (cyc >= m_due) && m_g;
      chk1("req_ready_0", req_ready_0, e_r0);
      chk1("req_ready_1", req_ready_1, e_r1);
      chk1("rsp_valid_0", rsp_valid_0, e_v0);
      chk1("rsp_valid_1", rsp_valid_1, e_v1);
      if (e_v0 || e_v1) begin
        m_clean = 1'b0;
        chk("rsp_result", rsp_result, m_exp[34:3]);
        chk1("rsp_carry", rsp_carry, m_exp[2]);
        chk1("rsp_overflow", rsp_overflow, m_exp[1]);
        chk1("rsp_zero", rsp_zero, m_exp[0]);
        chk1("rsp_err", rsp_err, m_err);
      end else if (m_clean) begin
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk1("reset_rsp_flags", rsp_carry | rsp_overflow | rsp_zero | rsp_err, 1'b0);
      end
      if (reset) begin
        m_busy  = 1'b0;
        m_prio  = INIT_PRIO;
        m_clean = 1'b1;
      end else if (!m_busy) begin
        if (req_valid[0] || req_valid[1]) begin
          m_busy = 1'b1;
          m_g    = mg;
          m_exp  = alu_fn(req_a[mg], req_b[mg], req_ctl[mg], req_shamt[mg]);
          m_err  = 1'b0;
          m_due  = cyc + 2;
          m_illegal = !(req_ctl[mg] == 4'b0000 || req_ctl[mg] == 4'b0010 || req_ctl[mg] >= 4'b1000)
                      || (req_ctl[mg] == 4'b1111);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
          if (m_illegal) begin
            m_exp = '0;
            m_err = 1'b1;
            m_due = cyc + 1;
          end
`endif
        end
      end else if (cyc >= m_due && rsp_ready[m_g]) begin
        m_busy = 1'b0;
        m_prio = !m_g;
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [4:0] s, output int hs);
    bit done;
    done = 1'b0;
    hs = -1;
    req_a[i] = a; req_b[i] = b; req_ctl[i] = c; req_shamt[i] = s; req_valid[i] = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((i == 0) ? req_ready_0 : req_ready_1) begin
        hs = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    if (!done) timeout_fail("issue_handshake");
  endtask

  task automatic wait_rsp(input int i, output int got, output logic [31:0] r,
                          output logic c, output logic v, output logic z, output logic e);
    bit done;
    done = 1'b0;
    got = -1; r = '0; c = 1'b0; v = 1'b0; z = 1'b0; e = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((i == 0) ? rsp_valid_0 : rsp_valid_1) begin
        got = cyc;
        r = rsp_result; c = rsp_carry; v = rsp_overflow; z = rsp_zero; e = rsp_err;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) timeout_fail("wait_response");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'(int'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  int          hs, got;
  logic [31:0] r;
  logic        c, v, z, e;
  bit          done;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_a[i] = '0; req_b[i] = '0; req_ctl[i] = '0; req_shamt[i] = '0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_state_idle", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;

    // Single add from requester 0.
    issue(0, 32'd5, 32'd7, 4'b1000, 5'd0, hs);
    wait_rsp(0, got, r, c, v, z, e);
    chk("t1_latency", got - hs, 32'd2);
    chk("t1_result", r, 32'd12);
    chk1("t1_carry", c, 1'b0);
    chk1("t1_overflow", v, 1'b0);
    chk1("t1_zero", z, 1'b0);

    // Simultaneous requests after reset: priority then round-robin.
    do_reset();
    req_a[0] = 32'd9; req_b[0] = 32'd9; req_ctl[0] = 4'b1010; req_shamt[0] = 5'd0; req_valid[0] = 1'b1;
    req_a[1] = 32'hF0; req_b[1] = 32'h0F; req_ctl[1] = 4'b1101; req_shamt[1] = 5'd0; req_valid[1] = 1'b1;
    @(negedge clk);
    chk1("t2_tie_ready_0", req_ready_0, 1'b1);
    chk1("t2_tie_ready_1", req_ready_1, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, got, r, c, v, z, e);
    chk("t2_req0_result", r, 32'd0);
    chk1("t2_req0_zero", z, 1'b1);
    issue(1, 32'hF0, 32'h0F, 4'b1101, 5'd0, hs);
    wait_rsp(1, got, r, c, v, z, e);
    chk("t2_req1_result", r, 32'hFF);
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_ctl[0] = 4'b1000; req_valid[0] = 1'b1;
    req_a[1] = 32'd3; req_b[1] = 32'd4; req_ctl[1] = 4'b1000; req_valid[1] = 1'b1;
    @(negedge clk);
    chk1("t2_third_tie_ready_0", req_ready_0, 1'b1);
    chk1("t2_third_tie_ready_1", req_ready_1, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    wait_rsp(0, got, r, c, v, z, e);
    chk("t2_third_result", r, 32'd3);

    // Signed-overflow subtract with a stalled response channel.
    rsp_ready[1] = 1'b0;
    issue(1, 32'h8000_0000, 32'd1, 4'b1010, 5'd0, hs);
    req_a[0] = 32'd3; req_b[0] = 32'd4; req_ctl[0] = 4'b1000; req_valid[0] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid_1) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) timeout_fail("t3_wait_valid");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; @(negedge clk); end
      chk1("t3_hold_valid_1", rsp_valid_1, 1'b1);
      chk("t3_hold_result", rsp_result, 32'h7FFF_FFFF);
      chk1("t3_hold_overflow", rsp_overflow, 1'b1);
      chk1("t3_blocked_ready_0", req_ready_0, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    issue(0, 32'd3, 32'd4, 4'b1000, 5'd0, hs);
    wait_rsp(0, got, r, c, v, z, e);
    chk("t3_req0_after_stall", r, 32'd7);

    // Shift left to the sign bit.
    issue(0, 32'd0, 32'd1, 4'b0000, 5'd31, hs);
    wait_rsp(0, got, r, c, v, z, e);
    chk("t4_sll_result", r, 32'h8000_0000);
    chk1("t4_sll_carry", c, 1'b0);
    chk1("t4_sll_overflow", v, 1'b0);

    // Reset while the op executes: it is discarded and priority returns to INIT_PRIO.
    issue(0, 32'd10, 32'd20, 4'b1000, 5'd0, hs);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("t5_rsp_valid_0", rsp_valid_0, 1'b0);
    chk1("t5_rsp_valid_1", rsp_valid_1, 1'b0);
    chk("t5_state_idle", {30'd0, dbg_state}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; @(negedge clk);
      chk1("t5_never_returned", rsp_valid_0, 1'b0);
    end
    @(posedge clk); #1;
    req_a[0] = 32'd6; req_b[0] = 32'd6; req_ctl[0] = 4'b1100; req_valid[0] = 1'b1;
    req_a[1] = 32'd5; req_b[1] = 32'd5; req_ctl[1] = 4'b1100; req_valid[1] = 1'b1;
    @(negedge clk);
    chk1("t5_prio_ready_0", req_ready_0, 1'b1);
    chk1("t5_prio_ready_1", req_ready_1, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    wait_rsp(0, got, r, c, v, z, e);
    chk("t5_after_reset_result", r, 32'd6);

    // Control code 0101.
    issue(0, 32'h1234, 32'h5678, 4'b0101, 5'd0, hs);
    wait_rsp(0, got, r, c, v, z, e);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    chk("t6_latency", got - hs, 32'd1);
    chk1("t6_err", e, 1'b1);
    chk("t6_result", r, 32'd0);
`else
    chk("t6_latency", got - hs, 32'd2);
    chk1("t6_err", e, 1'b0);
    chk("t6_result", r, ~(32'h1234 | 32'h5678));
`endif

    // Randomized traffic; requests may change or drop freely until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_a[i]     = rand_word();
        req_b[i]     = rand_word();
        req_ctl[i]   = 4'($urandom_range(0, 15));
        req_shamt[i] = 5'($urandom_range(0, 31));
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 299) == 0);
    end

    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
